// File: rtl/axilite_cmd_master_if.sv
// AXI-Lite bus bundle shared by initiators and targets.
interface axilite_if #(
  parameter int unsigned AWID = 32,
  parameter int unsigned DWID = 64
);
  logic [AWID-1:0]     awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DWID-1:0]     wdata;
  logic [DWID/8-1:0]   wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [AWID-1:0]     araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DWID-1:0]     rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axilite_cmd_master.sv
// Single-outstanding AXI-Lite initiator: one command in, one AXI transaction, one response out.
// A sticky stall flag reports any AXI phase that waits too long; the transaction is never dropped.
module axilite_cmd_master #(
  parameter int unsigned AWID = 32,
  parameter int unsigned BWL2 = 3,
  parameter int unsigned TOL2 = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  axilite_if.master                 axil,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_we,
  input  logic [AWID-1:0]           cmd_addr,
  input  logic [8*(2**BWL2)-1:0]    cmd_wdata,
  input  logic [(2**BWL2)-1:0]      cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_we,
  output logic [8*(2**BWL2)-1:0]    rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      stall
);

  localparam int unsigned DW = 8 * (2**BWL2);
  localparam int unsigned SW = 2**BWL2;

  // Watchdog saturation point and the value one below it.
  localparam logic [TOL2:0] WdMax  = {1'b1, {TOL2{1'b0}}};
  localparam logic [TOL2:0] WdLast = {1'b0, {TOL2{1'b1}}};

  typedef enum logic [2:0] {StIdle, StWr, StWrB, StRdA, StRdD, StRsp} state_e;

  state_e          state;
  logic [AWID-1:0] addr_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic            awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
  logic [TOL2:0]   wd_cnt;

  logic aw_done, w_done, ar_fire, b_fire, r_fire, waiting;

  assign axil.awaddr  = addr_q;
  assign axil.awprot  = 3'b000;
  assign axil.awvalid = awvalid_q;
  assign axil.wdata   = wdata_q;
  assign axil.wstrb   = wstrb_q;
  assign axil.wvalid  = wvalid_q;
  assign axil.bready  = bready_q;
  assign axil.araddr  = addr_q;
  assign axil.arprot  = 3'b000;
  assign axil.arvalid = arvalid_q;
  assign axil.rready  = rready_q;

  // Handshake decode; a write channel counts as done once its valid has dropped or fires now.
  always_comb begin
    aw_done = !awvalid_q || axil.awready;
    w_done  = !wvalid_q || axil.wready;
    ar_fire = arvalid_q && axil.arready;
    b_fire  = bready_q && axil.bvalid;
    r_fire  = rready_q && axil.rvalid;
    waiting = (state == StWr) || (state == StWrB) || (state == StRdA) || (state == StRdD);
  end

  // Transaction FSM with registered AXI/response outputs and the stall watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
      stall     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      wd_cnt    <= '0;
    end else begin
      // Count wait cycles; any state change below overrides this with a clear.
      if (waiting && wd_cnt != WdMax) begin
        wd_cnt <= wd_cnt + 1'b1;
        if (wd_cnt == WdLast) stall <= 1'b1;
      end

      unique case (state)
        StIdle: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            wd_cnt    <= '0;
            if (cmd_we) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= StWr;
            end else begin
              arvalid_q <= 1'b1;
              state     <= StRdA;
            end
          end
        end
        StWr: begin
          if (axil.awready) awvalid_q <= 1'b0;
          if (axil.wready) wvalid_q <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            wd_cnt   <= '0;
            state    <= StWrB;
          end
        end
        StWrB: begin
          if (b_fire) begin
            rsp_resp  <= axil.bresp;
            rsp_rdata <= '0;
            rsp_we    <= 1'b1;
            rsp_valid <= 1'b1;
            bready_q  <= 1'b0;
            wd_cnt    <= '0;
            state     <= StRsp;
          end
        end
        StRdA: begin
          if (ar_fire) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            wd_cnt    <= '0;
            state     <= StRdD;
          end
        end
        StRdD: begin
          if (r_fire) begin
            rsp_rdata <= axil.rdata;
            rsp_resp  <= axil.rresp;
            rsp_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rready_q  <= 1'b0;
            wd_cnt    <= '0;
            state     <= StRsp;
          end
        end
        StRsp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axilite_cmd_master.sv
// Directed bench for axilite_cmd_master; the bench itself plays the AXI-Lite slave.
module tb_axilite_cmd_master;

  localparam int unsigned AWID = 32;
  localparam int unsigned BWL2 = 3;
  localparam int unsigned TOL2 = 4;
  localparam int unsigned DW   = 64;
  localparam int unsigned SW   = 8;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } rsp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid, cmd_ready, cmd_we;
  logic [AWID-1:0] cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [SW-1:0]   cmd_wstrb;
  logic            rsp_valid, rsp_ready, rsp_we;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;
  logic            stall;

  axilite_if #(.AWID(AWID), .DWID(DW)) axil ();

  axilite_cmd_master #(.AWID(AWID), .BWL2(BWL2), .TOL2(TOL2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .axil      (axil),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_we    (rsp_we),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   aw_hs = 0, w_hs = 0, b_hs = 0;
  rsp_t exp_q[$];

  // Count handshakes as the slave sees them.
  always @(posedge clk) begin
    if (axil.awvalid && axil.awready) aw_hs <= aw_hs + 1;
    if (axil.wvalid && axil.wready) w_hs <= w_hs + 1;
    if (axil.bvalid && axil.bready) b_hs <= b_hs + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                          input logic [7:0] ws, input logic [63:0] rd, input logic [1:0] resp);
    rsp_t e;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_wstrb = ws;
    e.we    = we;
    e.rdata = we ? 64'h0 : rd;
    e.resp  = resp;
    exp_q.push_back(e);
    step();
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for a response, compare it against the scoreboard, then accept it.
  task automatic take_rsp(input string tag);
    rsp_t e;
    int   n = 0;
    while (!rsp_valid && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_queue"}, (exp_q.size() > 0), 1);
    if (rsp_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_rsp_we"}, rsp_we, e.we);
      chk({tag, "_rsp_rdata"}, rsp_rdata, e.rdata);
      chk({tag, "_rsp_resp"}, rsp_resp, e.resp);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk({tag, "_rsp_drop"}, rsp_valid, 0);
      chk({tag, "_cmd_ready_back"}, cmd_ready, 1);
    end
  endtask

  // Write whose AW and W handshakes are four cycles apart, in either order.
  task automatic split_write(input logic aw_first, input logic [31:0] addr, input string tag);
    int aw0 = aw_hs;
    int w0  = w_hs;
    axil.awready = aw_first;
    axil.wready  = !aw_first;
    send_cmd(1'b1, addr, 64'hCAFE_0000_0000_0000 | 64'(addr), 8'h0F, 64'h0, 2'b00);
    step();
    axil.awready = 1'b0;
    axil.wready  = 1'b0;
    chk({tag, "_first_dropped"}, aw_first ? axil.awvalid : axil.wvalid, 0);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_other_held"}, aw_first ? axil.wvalid : axil.awvalid, 1);
      chk({tag, "_bready_early"}, axil.bready, 0);
      step();
    end
    if (aw_first) axil.wready = 1'b1;
    else axil.awready = 1'b1;
    step();
    axil.awready = 1'b0;
    axil.wready  = 1'b0;
    chk({tag, "_both_dropped"}, {axil.awvalid, axil.wvalid}, 0);
    chk({tag, "_bready"}, axil.bready, 1);
    axil.bvalid = 1'b1;
    step();
    axil.bvalid = 1'b0;
    take_rsp(tag);
    chk({tag, "_aw_count"}, aw_hs - aw0, 1);
    chk({tag, "_w_count"}, w_hs - w0, 1);
  endtask

  initial begin
    int b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    axil.awready = 1'b0; axil.wready = 1'b0; axil.arready = 1'b0;
    axil.bvalid = 1'b0; axil.bresp = 2'b00;
    axil.rvalid = 1'b0; axil.rdata = '0; axil.rresp = 2'b00;

    // Reset values.
    #2;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_axi_valids", {axil.awvalid, axil.wvalid, axil.arvalid, axil.bready, axil.rready}, 0);
    chk("rst_awaddr", axil.awaddr, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    step();
    step();
    rst_n = 1'b1;
    chk("cmd_ready_pre_edge", cmd_ready, 0);
    step();
    chk("cmd_ready_after_release", cmd_ready, 1);

    // Zero-wait write.
    axil.awready = 1'b1;
    axil.wready  = 1'b1;
    b0 = b_hs;
    send_cmd(1'b1, 32'h40, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 2'b00);
    chk("wr_cmd_ready_low", cmd_ready, 0);
    chk("wr_awvalid", axil.awvalid, 1);
    chk("wr_wvalid", axil.wvalid, 1);
    chk("wr_awaddr", axil.awaddr, 32'h40);
    chk("wr_wdata", axil.wdata, 64'h1122_3344_5566_7788);
    chk("wr_wstrb", axil.wstrb, 8'hFF);
    chk("wr_awprot", axil.awprot, 0);
    step();
    axil.awready = 1'b0;
    axil.wready  = 1'b0;
    chk("wr_valids_dropped", {axil.awvalid, axil.wvalid}, 0);
    chk("wr_bready", axil.bready, 1);
    axil.bvalid = 1'b1;
    step();
    axil.bvalid = 1'b0;
    chk("wr_rsp_at_n3", rsp_valid, 1);
    chk("wr_bready_dropped", axil.bready, 0);
    take_rsp("wr0");
    chk("wr_b_count", b_hs - b0, 1);

    // Read with three arready wait cycles.
    send_cmd(1'b0, 32'h48, 64'h0, 8'h00, 64'hDEAD_BEEF_0000_0001, 2'b00);
    chk("rd_araddr", axil.araddr, 32'h48);
    for (int i = 0; i < 3; i++) begin
      chk("rd_arvalid_held", axil.arvalid, 1);
      step();
    end
    chk("rd_arvalid_at_ready", axil.arvalid, 1);
    axil.arready = 1'b1;
    step();
    axil.arready = 1'b0;
    chk("rd_arvalid_dropped", axil.arvalid, 0);
    chk("rd_rready", axil.rready, 1);
    axil.rvalid = 1'b1;
    axil.rdata  = 64'hDEAD_BEEF_0000_0001;
    step();
    axil.rvalid = 1'b0;
    axil.rdata  = '0;
    chk("rd_rready_dropped", axil.rready, 0);
    take_rsp("rd0");

    // Split write handshakes, both orders.
    split_write(1'b0, 32'h80, "split_w_first");
    split_write(1'b1, 32'h84, "split_aw_first");

    // Response back-pressure on a zero-wait read.
    axil.arready = 1'b1;
    send_cmd(1'b0, 32'h50, 64'h0, 8'h00, 64'hA5A5_5A5A_0F0F_F0F0, 2'b00);
    step();
    axil.arready = 1'b0;
    axil.rvalid  = 1'b1;
    axil.rdata   = 64'hA5A5_5A5A_0F0F_F0F0;
    step();
    axil.rvalid  = 1'b0;
    axil.rdata   = '0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_rdata", rsp_rdata, 64'hA5A5_5A5A_0F0F_F0F0);
      chk("bp_rsp_we", rsp_we, 0);
      chk("bp_cmd_ready", cmd_ready, 0);
      step();
    end
    take_rsp("bp");
    chk("no_stall_yet", stall, 0);

    // Stall watchdog: arready withheld 20 cycles, slave answers with SLVERR.
    send_cmd(1'b0, 32'h60, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 2'b10);
    for (int i = 0; i < 20; i++) begin
      if (i == 15) chk("stall_before_16", stall, 0);
      if (i == 16) chk("stall_at_16", stall, 1);
      if (i == 19) chk("stall_arvalid_held", axil.arvalid, 1);
      step();
    end
    axil.arready = 1'b1;
    step();
    axil.arready = 1'b0;
    chk("stall_rready", axil.rready, 1);
    axil.rvalid = 1'b1;
    axil.rdata  = 64'h0123_4567_89AB_CDEF;
    axil.rresp  = 2'b10;
    step();
    axil.rvalid = 1'b0;
    axil.rdata  = '0;
    axil.rresp  = 2'b00;
    take_rsp("stall_rd");
    chk("stall_sticky", stall, 1);

    // Asynchronous reset while waiting in WR_B.
    axil.awready = 1'b1;
    axil.wready  = 1'b1;
    send_cmd(1'b1, 32'h90, 64'h55, 8'h01, 64'h0, 2'b00);
    step();
    axil.awready = 1'b0;
    axil.wready  = 1'b0;
    chk("mid_wrb_bready", axil.bready, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valids", {axil.awvalid, axil.wvalid, axil.arvalid, axil.bready, axil.rready}, 0);
    chk("arst_cmd_ready", cmd_ready, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_stall", stall, 0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    chk("arst_cmd_ready_held", cmd_ready, 0);
    step();
    chk("arst_cmd_ready_back", cmd_ready, 1);

    // A normal write completes after the reset.
    axil.awready = 1'b1;
    axil.wready  = 1'b1;
    axil.bresp   = 2'b11;
    send_cmd(1'b1, 32'hA0, 64'hFEED, 8'h03, 64'h0, 2'b11);
    step();
    axil.awready = 1'b0;
    axil.wready  = 1'b0;
    chk("post_rst_bready", axil.bready, 1);
    axil.bvalid = 1'b1;
    step();
    axil.bvalid = 1'b0;
    axil.bresp  = 2'b00;
    take_rsp("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
